// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory-access controller.
//   size_e    : request size encodings (byte, half, word, reserved)
//   state_e   : controller FSM states
//   lane_sel  : byte-lane index of an address, honouring endianness
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  // Big-endian places byte address 0 in the most significant lane.
  function automatic logic [1:0] lane_sel(input logic [1:0] addr_lo,
                                          input logic       big_endian);
    return big_endian ? (addr_lo ^ 2'b11) : addr_lo;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the pipeline-request and data-memory signals of mem_access_ctrl.
//   slave  : controller view (requests and dm_rdata in, results and dm_* out)
//   master : environment view (pipeline + memory)
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        misalign_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  dm_rdata,
    output stall, load_data, misalign_err,
    output dm_addr, dm_wdata, dm_read, dm_write
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output dm_rdata,
    input  stall, load_data, misalign_err,
    input  dm_addr, dm_wdata, dm_read, dm_write
  );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational lane handling for one 32-bit memory word.
//   store_i = 0 : extract byte/half at lane_i from word_i and sign- or
//                 zero-extend (unsigned_i); word size passes word_i through.
//   store_i = 1 : return word_i with the byte/half at lane_i replaced by
//                 wdata_i[7:0] / wdata_i[15:0].
// Ports: word_i, lane_i (byte lane), size_i, unsigned_i, store_i, wdata_i in;
//        data_o out.
module lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic        store_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    // A halfword occupies the upper or lower half selected by lane bit 1.
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    data_o   = word_i;
    if (store_i) begin
      case (size_i)
        SZ_BYTE: data_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
        SZ_HALF: begin
          if (lane_i[1]) data_o[31:16] = wdata_i;
          else           data_o[15:0]  = wdata_i;
        end
        default: data_o = word_i;
      endcase
    end else begin
      case (size_i)
        SZ_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        SZ_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        SZ_WORD: data_o = word_i;
        default: data_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory-access controller: turns byte/half/word loads and stores
// into word accesses of a word-addressed data memory. Loads and word stores
// complete in one cycle; sub-word stores are a read-modify-write that stalls
// the pipeline for the read cycle and writes the merged word in the next.
// Ports: clk, rst (sync, active high); bus (slave modport) carries the
// pipeline request/result signals and the data-memory port.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BIG_ENDIAN = 0
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   wbuf_q, wbuf_d;
  logic [31:0]         abuf_q, abuf_d;

  size_e       req_size;
  logic [1:0]  lane;
  logic [31:0] word_addr;
  logic        misalign;
  logic [31:0] ext_data;
  logic [31:0] merge_data;

  assign req_size  = size_e'(bus.req_size);
  assign lane      = lane_sel(bus.req_addr[1:0], BIG_ENDIAN != 0);
  assign word_addr = {bus.req_addr[31:2], 2'b00};
  assign misalign  = (req_size == SZ_RSVD) ||
                     ((req_size == SZ_HALF) && bus.req_addr[0]) ||
                     ((req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

  lane_align u_load_align (
    .word_i     (bus.dm_rdata),
    .lane_i     (lane),
    .size_i     (req_size),
    .unsigned_i (bus.req_unsigned),
    .store_i    (1'b0),
    .wdata_i    (16'h0000),
    .data_o     (ext_data)
  );

  lane_align u_store_align (
    .word_i     (bus.dm_rdata),
    .lane_i     (lane),
    .size_i     (req_size),
    .unsigned_i (1'b0),
    .store_i    (1'b1),
    .wdata_i    (bus.req_wdata[15:0]),
    .data_o     (merge_data)
  );

  always_comb begin
    state_d          = state_q;
    wbuf_d           = wbuf_q;
    abuf_d           = abuf_q;
    bus.stall        = 1'b0;
    bus.load_data    = '0;
    bus.misalign_err = 1'b0;
    bus.dm_addr      = word_addr;
    bus.dm_wdata     = bus.req_wdata;
    bus.dm_read      = 1'b0;
    bus.dm_write     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (misalign) begin
            bus.misalign_err = 1'b1;
          end else if (!bus.req_write) begin
            bus.dm_read   = 1'b1;
            bus.load_data = ext_data;
          end else if (req_size == SZ_WORD) begin
            bus.dm_write = 1'b1;
          end else begin
            bus.dm_read = 1'b1;
            bus.stall   = 1'b1;
            wbuf_d      = merge_data;
            abuf_d      = word_addr;
            state_d     = WRITE;
          end
        end
      end
      WRITE: begin
        bus.dm_write = 1'b1;
        bus.dm_addr  = abuf_q;
        bus.dm_wdata = wbuf_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset gates every enable, so a WRITE cycle under reset never reaches memory.
    if (rst) begin
      bus.stall        = 1'b0;
      bus.load_data    = '0;
      bus.misalign_err = 1'b0;
      bus.dm_read      = 1'b0;
      bus.dm_write     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wbuf_q  <= '0;
      abuf_q  <= '0;
    end else begin
      state_q <= state_d;
      wbuf_q  <= wbuf_d;
      abuf_q  <= abuf_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();
  mem_access_ctrl_if be_bus ();

  mem_access_ctrl #(.DATA_W(32), .BIG_ENDIAN(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mem_access_ctrl #(.DATA_W(32), .BIG_ENDIAN(1)) dut_be (
    .clk (clk),
    .rst (rst),
    .bus (be_bus.slave)
  );

  // Word-addressed memory model, combinational read, write at rising edge.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (preload) mem[64] <= 32'hAABBCCDD;
    else if (bus.dm_write) mem[bus.dm_addr[11:2]] <= bus.dm_wdata;
  end
  assign bus.dm_rdata    = mem[bus.dm_addr[11:2]];
  assign be_bus.dm_rdata = mem[be_bus.dm_addr[11:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid    = v;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
  endtask

  task automatic drive_be(input logic v, input logic [1:0] sz, input logic u,
                          input logic [31:0] a);
    be_bus.req_valid    = v;
    be_bus.req_write    = 1'b0;
    be_bus.req_size     = sz;
    be_bus.req_unsigned = u;
    be_bus.req_addr     = a;
    be_bus.req_wdata    = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic pre);
    rst     = 1'b1;
    preload = pre;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive_be(1'b0, 2'b00, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    preload = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        v, w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a, wd;
    logic        e_rd, e_wr, e_err;
    logic [31:0] e_ld, e_addr, e_wd;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"lb_101",   1, 0, 2'b00, 0, 32'h101, 32'h0,        1, 0, 0, 32'hFFFFFFCC, 32'h100, 32'h0};
    vecs[1]  = '{"lbu_101",  1, 0, 2'b00, 1, 32'h101, 32'h0,        1, 0, 0, 32'h000000CC, 32'h100, 32'h0};
    vecs[2]  = '{"lh_102",   1, 0, 2'b01, 0, 32'h102, 32'h0,        1, 0, 0, 32'hFFFFAABB, 32'h100, 32'h0};
    vecs[3]  = '{"lhu_100",  1, 0, 2'b01, 1, 32'h100, 32'h0,        1, 0, 0, 32'h0000CCDD, 32'h100, 32'h0};
    vecs[4]  = '{"lb_103",   1, 0, 2'b00, 0, 32'h103, 32'h0,        1, 0, 0, 32'hFFFFFFAA, 32'h100, 32'h0};
    vecs[5]  = '{"lbu_100",  1, 0, 2'b00, 1, 32'h100, 32'h0,        1, 0, 0, 32'h000000DD, 32'h100, 32'h0};
    vecs[6]  = '{"lw_100",   1, 0, 2'b10, 0, 32'h100, 32'h0,        1, 0, 0, 32'hAABBCCDD, 32'h100, 32'h0};
    vecs[7]  = '{"lh_101_mis", 1, 0, 2'b01, 0, 32'h101, 32'h0,      0, 0, 1, 32'h0, 32'h0, 32'h0};
    vecs[8]  = '{"sw_102_mis", 1, 1, 2'b10, 0, 32'h102, 32'hDEADBEEF, 0, 0, 1, 32'h0, 32'h0, 32'h0};
    vecs[9]  = '{"rsvd_size", 1, 0, 2'b11, 0, 32'h100, 32'h0,       0, 0, 1, 32'h0, 32'h0, 32'h0};
    vecs[10] = '{"no_req",   0, 0, 2'b10, 0, 32'h100, 32'h0,        0, 0, 0, 32'h0, 32'h0, 32'h0};
    vecs[11] = '{"sw_200",   1, 1, 2'b10, 0, 32'h200, 32'h12345678, 0, 1, 0, 32'h0, 32'h200, 32'h12345678};
    vecs[12] = '{"lw_200",   1, 0, 2'b10, 0, 32'h200, 32'h0,        1, 0, 0, 32'h12345678, 32'h200, 32'h0};
    vecs[13] = '{"lw_100_unchanged", 1, 0, 2'b10, 0, 32'h100, 32'h0, 1, 0, 0, 32'hAABBCCDD, 32'h100, 32'h0};

    rst     = 1'b1;
    preload = 1'b1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    drive_be(1'b0, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst_stall",   {31'b0, bus.stall},   32'h0);
    chk("rst_dm_read", {31'b0, bus.dm_read}, 32'h0);
    chk("rst_load",    bus.load_data,        32'h0);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0);
    #1;
    chk("rst_sb_stall", {31'b0, bus.stall}, 32'h0);
    do_reset(1'b1);

    for (int unsigned i = 0; i < 14; i++) begin
      drive(vecs[i].v, vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd);
      @(negedge clk);
      chk({vecs[i].name, "_stall"}, {31'b0, bus.stall},        32'h0);
      chk({vecs[i].name, "_read"},  {31'b0, bus.dm_read},      {31'b0, vecs[i].e_rd});
      chk({vecs[i].name, "_write"}, {31'b0, bus.dm_write},     {31'b0, vecs[i].e_wr});
      chk({vecs[i].name, "_err"},   {31'b0, bus.misalign_err}, {31'b0, vecs[i].e_err});
      chk({vecs[i].name, "_load"},  bus.load_data,             vecs[i].e_ld);
      if (vecs[i].e_rd || vecs[i].e_wr) chk({vecs[i].name, "_addr"}, bus.dm_addr, vecs[i].e_addr);
      if (vecs[i].e_wr) chk({vecs[i].name, "_wdata"}, bus.dm_wdata, vecs[i].e_wd);
      next_cycle();
    end

    // sh 0x1234 @0x102, then lw, then two back-to-back sb RMWs.
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234);
    @(negedge clk);
    chk("sh_rd_stall", {31'b0, bus.stall},    32'h1);
    chk("sh_rd_read",  {31'b0, bus.dm_read},  32'h1);
    chk("sh_rd_write", {31'b0, bus.dm_write}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("sh_wr_stall", {31'b0, bus.stall},    32'h0);
    chk("sh_wr_read",  {31'b0, bus.dm_read},  32'h0);
    chk("sh_wr_write", {31'b0, bus.dm_write}, 32'h1);
    chk("sh_wr_addr",  bus.dm_addr,           32'h100);
    chk("sh_wr_wdata", bus.dm_wdata,          32'h1234CCDD);
    next_cycle();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    chk("sh_lw_stall", {31'b0, bus.stall}, 32'h0);
    chk("sh_lw_load",  bus.load_data,      32'h1234CCDD);
    next_cycle();
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h101, 32'h55);
    @(negedge clk);
    chk("sb55_stall", {31'b0, bus.stall}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("sb55_wdata", bus.dm_wdata, 32'h123455DD);
    next_cycle();
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h100, 32'h77);
    @(negedge clk);
    chk("sb77_stall", {31'b0, bus.stall}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("sb77_write", {31'b0, bus.dm_write}, 32'h1);
    chk("sb77_wdata", bus.dm_wdata, 32'h12345577);
    next_cycle();

    // sb 0xEE @0x100 with reset during the WRITE cycle.
    do_reset(1'b1);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h100, 32'hEE);
    @(negedge clk);
    chk("sbrst_stall", {31'b0, bus.stall}, 32'h1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("sbrst_write", {31'b0, bus.dm_write}, 32'h0);
    chk("sbrst_stall2", {31'b0, bus.stall},   32'h0);
    next_cycle();
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    chk("sbrst_lw_stall", {31'b0, bus.stall},   32'h0);
    chk("sbrst_lw_read",  {31'b0, bus.dm_read}, 32'h1);
    chk("sbrst_lw_load",  bus.load_data,        32'hAABBCCDD);
    next_cycle();

    // sb 0x11 @0x103 followed directly by lhu 0x102.
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h103, 32'h11);
    @(negedge clk);
    chk("sb11_stall", {31'b0, bus.stall}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("sb11_wdata", bus.dm_wdata, 32'h11BBCCDD);
    next_cycle();
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    @(negedge clk);
    chk("lhu102_stall", {31'b0, bus.stall}, 32'h0);
    chk("lhu102_load",  bus.load_data,      32'h000011BB);
    next_cycle();

    // Big-endian instance.
    do_reset(1'b1);
    drive_be(1'b1, 2'b00, 1'b1, 32'h100);
    @(negedge clk);
    chk("be_lbu100_load", be_bus.load_data, 32'h000000AA);
    chk("be_lbu100_read", {31'b0, be_bus.dm_read}, 32'h1);
    chk("be_lbu100_write", {31'b0, be_bus.dm_write}, 32'h0);
    next_cycle();
    drive_be(1'b1, 2'b01, 1'b1, 32'h100);
    @(negedge clk);
    chk("be_lhu100_load", be_bus.load_data, 32'h0000AABB);
    next_cycle();
    drive_be(1'b1, 2'b00, 1'b0, 32'h103);
    @(negedge clk);
    chk("be_lb103_load", be_bus.load_data, 32'hFFFFFFDD);
    next_cycle();
    drive_be(1'b0, 2'b00, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-access controller between the MIPS MEM pipeline stage and the word-addressed data memory. It turns byte, halfword and word loads and stores into 32-bit memory operations. Loads are lane-extracted and sign/zero-extended. Sub-word stores are done as a two-cycle read-modify-write, and the controller stalls the pipeline for the read cycle.

## Interface
Parameters:
- `DATA_W`, 32: data width; only 32 is supported.
- `BIG_ENDIAN`, 0: 0 means byte lane = `addr[1:0]`; 1 means lane = `addr[1:0] ^ 2'b11`.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  MEM stage has a memory op this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  zero-extend loads (lbu/lhu).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `stall`  out  1  freeze pipeline; request inputs must stay stable while high.
- `load_data`  out  32  extended load result, valid in the request cycle.
- `misalign_err`  out  1  one-cycle pulse: misaligned address or reserved size.
- `dm_addr`  out  32  to memory address.
- `dm_wdata`  out  32  to memory write data.
- `dm_read`  out  1  to memory read enable.
- `dm_write`  out  1  to memory write enable; the memory samples it at the rising edge.
- `dm_rdata`  in  32  from memory; combinational read of `dm_addr` while `dm_read`=1.

## Operation
- FSM states: IDLE, WRITE. Registers: `state`, `wbuf[31:0]`, `abuf[31:0]`.
- Misaligned request: half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11.
  - Sets `misalign_err`=1 for the cycle.
  - No `dm_read`, no `dm_write`, no stall; `load_data`=0.
- Load (IDLE):
  - `dm_read`=1, `dm_addr`={addr[31:2],2'b00}.
  - `load_data` = selected lane of `dm_rdata`, extended per `req_unsigned`.
  - Single cycle, no stall.
- Word store (IDLE): `dm_write`=1, `dm_wdata`=`req_wdata`, single cycle, no stall.
- Sub-word store, IDLE cycle:
  - `dm_read`=1, `stall`=1.
  - At the edge, `wbuf` ← `dm_rdata` with the target lane(s) replaced by `req_wdata[7:0]` or `req_wdata[15:0]`; `abuf` ← word address; state → WRITE.
- Sub-word store, WRITE cycle:
  - `dm_write`=1, `dm_addr`=`abuf`, `dm_wdata`=`wbuf`, `stall`=0, `dm_read`=0.
  - The pipeline advances at this edge; state → IDLE.
- `req_valid`=0 in IDLE: all memory enables 0, `load_data`=0, `stall`=0.
- Inputs are ignored in WRITE; the held request is the same store.

## Timing
- Reset:
  - State IDLE, `wbuf`=0, `abuf`=0.
  - While `rst`=1, `stall`, `dm_read`, `dm_write`, `misalign_err` and `load_data` are forced to 0.
- Reset asserted in the WRITE cycle: `dm_write` is gated by `!rst`, so memory is not written; state → IDLE.
- Latency: loads and word stores take 1 cycle. Sub-word stores take 2 cycles, with `stall` high for exactly 1 cycle.
- Back-to-back operations:
  - A load issued in the cycle after WRITE reads the updated word, because the memory writes at the WRITE edge.
  - A new sub-word store directly after WRITE starts a fresh RMW.
- `misalign_err` and the load path are combinational from the request. `stall` and the memory controls are combinational from `state` and the request.

## Structure
- Package `mem_access_pkg` holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - state enum IDLE/WRITE;
  - a lane-select function that applies `BIG_ENDIAN`.
- Sub-module `lane_align` (combinational): byte/half extract plus sign/zero extension for loads, and lane merge for stores. It is instantiated once for each of the two uses.
- Top level holds only the FSM, `wbuf`, `abuf` and output muxing.

## Test plan
All scenarios preload memory with word 0x100 = 0xAABBCCDD, `BIG_ENDIAN`=0.
- lb 0x101 → `load_data`=0xFFFFFFCC. lbu 0x101 → 0x000000CC. Both: `dm_read`=1, `stall`=0.
- sh 0x1234 at 0x102 → `stall`=1 for one cycle, then `dm_write`=1 with `dm_addr`=0x100 and `dm_wdata`=0x1234CCDD. The following lw 0x100 returns 0x1234CCDD.
- lh 0x101 and sw 0x102 → `misalign_err` pulses 1 cycle each, no `dm_read`/`dm_write`, memory unchanged.
- sb 0xEE at 0x100 with `rst`=1 in the WRITE cycle → `dm_write` stays 0 and memory keeps 0xAABBCCDD. After reset, `stall`=0 and state is IDLE.
- sb 0x11 at 0x103 immediately followed by lhu 0x102 → second op returns 0x000011BB with no extra stall.
- `BIG_ENDIAN`=1: lbu 0x100 → 0x000000AA.
